// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD (sequential double dabble) plus 4-digit multiplexed common-anode 7-segment scan.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros of the hundreds/tens digits.
module seg7_scan_driver #(
    parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
    input  logic       system_clock,
    input  logic       system_reset,
    input  logic [8:0] value,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       conv_busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] dabble_adjust(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

    // Scan datapath
    logic [15:0] presc_q;
    logic        tick;
    logic        scan_on_q;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic [6:0]  seg_d;
    logic [11:0] shadow_q;
    logic [11:0] disp_q;
    logic [11:0] disp_d;

    // Conversion engine
    conv_state_e state_q;
    logic        first_q;
    logic        busy_q;
    logic [8:0]  bin_q;
    logic [11:0] bcd_q;
    logic [11:0] bcd_adj;
    logic [20:0] dabble_shift;
    logic [3:0]  shift_cnt_q;
    logic        conv_trigger;

    assign tick = (presc_q == REFRESH_DIV - 16'd1);

    assign bcd_adj      = {dabble_adjust(bcd_q[11:8]), dabble_adjust(bcd_q[7:4]), dabble_adjust(bcd_q[3:0])};
    assign dabble_shift = {bcd_adj, bin_q} << 1;

    // A new conversion starts on the tick that moves the scan onto digit 3, so its result
    // is in the shadow registers before the following digit-0 tick commits it.
    assign conv_trigger = first_q || (tick && (idx_d == 2'd3));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        idx_d  = scan_on_q ? idx_q + 2'd1 : 2'd0;
        disp_d = (idx_d == 2'd0) ? shadow_q : disp_q;
        seg_d  = SEG_BLANK;
        case (idx_d)
            2'd0: seg_d = seg_encode(disp_d[3:0]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            2'd1: seg_d = (disp_d[11:4] == 8'd0) ? SEG_BLANK : seg_encode(disp_d[7:4]);
            2'd2: seg_d = (disp_d[11:8] == 4'd0) ? SEG_BLANK : seg_encode(disp_d[11:8]);
`else
            2'd1: seg_d = seg_encode(disp_d[7:4]);
            2'd2: seg_d = seg_encode(disp_d[11:8]);
`endif
            default: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            presc_q   <= 16'd0;
            scan_on_q <= 1'b0;
            idx_q     <= 2'd0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
            disp_q    <= 12'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            presc_q <= tick ? 16'd0 : presc_q + 16'd1;
            if (tick) begin
                scan_on_q <= 1'b1;
                idx_q     <= idx_d;
                an_q      <= ~(4'b0001 << idx_d);
                seg_q     <= seg_d;
                disp_q    <= disp_d;
            end
        end
    end

    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            state_q     <= IDLE;
            first_q     <= 1'b1;
            busy_q      <= 1'b0;
            bin_q       <= 9'd0;
            bcd_q       <= 12'd0;
            shift_cnt_q <= 4'd0;
            shadow_q    <= 12'd0;
        end else begin
            first_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (conv_trigger) begin
                        bin_q       <= value;
                        bcd_q       <= 12'd0;
                        shift_cnt_q <= 4'd0;
                        busy_q      <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= dabble_shift;
                    shift_cnt_q    <= shift_cnt_q + 4'd1;
                    if (shift_cnt_q == 4'd8) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    shadow_q <= bcd_q;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = 1'b1;
    assign conv_busy = busy_q;

endmodule
